// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard unit.
package hazard_pkg;

  // Architectural register address width (16 registers).
  localparam int REG_AW = 4;

  // Register number that aliases the PC; it never participates in forwarding.
  localparam int PC_REG = 15;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Pick the forwarding source. The M-stage result is younger, so it wins over W.
  function automatic fwd_sel_e fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m) begin
      return FWD_MEM;
    end else if (hit_w) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/hazard_tagpipe.sv
// E/M/W register-tag pipeline. Shadows the datapath pipeline registers so the
// hazard unit knows which registers the in-flight instructions read and write.
module hazard_tagpipe
  import hazard_pkg::*;
#(
  parameter int REG_AW = hazard_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_e_i,
  input  logic [REG_AW-1:0] ra1_d_i,
  input  logic [REG_AW-1:0] ra2_d_i,
  input  logic [REG_AW-1:0] wa3_d_i,
  output logic              vld_e_o,
  output logic [REG_AW-1:0] ra1_e_o,
  output logic [REG_AW-1:0] ra2_e_o,
  output logic [REG_AW-1:0] wa3_e_o,
  output logic              vld_m_o,
  output logic [REG_AW-1:0] wa3_m_o,
  output logic              vld_w_o,
  output logic [REG_AW-1:0] wa3_w_o
);

  logic              vld_e_q, vld_e_d;
  logic [REG_AW-1:0] ra1_e_q, ra1_e_d;
  logic [REG_AW-1:0] ra2_e_q, ra2_e_d;
  logic [REG_AW-1:0] wa3_e_q, wa3_e_d;
  logic              vld_m_q, vld_m_d;
  logic [REG_AW-1:0] wa3_m_q, wa3_m_d;
  logic              vld_w_q, vld_w_d;
  logic [REG_AW-1:0] wa3_w_q, wa3_w_d;

  // Next-state: D tags advance into E (bubbled on flush); M and W always shift.
  always_comb begin
    vld_e_d = ~flush_e_i;
    ra1_e_d = ra1_d_i;
    ra2_e_d = ra2_d_i;
    wa3_e_d = wa3_d_i;
    vld_m_d = vld_e_q;
    wa3_m_d = wa3_e_q;
    vld_w_d = vld_m_q;
    wa3_w_d = wa3_m_q;
  end

  // Tag registers; reset empties every stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_e_q <= 1'b0;
      ra1_e_q <= '0;
      ra2_e_q <= '0;
      wa3_e_q <= '0;
      vld_m_q <= 1'b0;
      wa3_m_q <= '0;
      vld_w_q <= 1'b0;
      wa3_w_q <= '0;
    end else begin
      vld_e_q <= vld_e_d;
      ra1_e_q <= ra1_e_d;
      ra2_e_q <= ra2_e_d;
      wa3_e_q <= wa3_e_d;
      vld_m_q <= vld_m_d;
      wa3_m_q <= wa3_m_d;
      vld_w_q <= vld_w_d;
      wa3_w_q <= wa3_w_d;
    end
  end

  assign vld_e_o = vld_e_q;
  assign ra1_e_o = ra1_e_q;
  assign ra2_e_o = ra2_e_q;
  assign wa3_e_o = wa3_e_q;
  assign vld_m_o = vld_m_q;
  assign wa3_m_o = wa3_m_q;
  assign vld_w_o = vld_w_q;
  assign wa3_w_o = wa3_w_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall, control
// flush for PC writes and taken branches, plus saturating stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = hazard_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(PC_REG);

  logic              vld_e, vld_m, vld_w;
  logic [REG_AW-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic              hit_am, hit_aw, hit_bm, hit_bw;
  logic              ldr_stall, pc_wr_pending;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_tagpipe #(
    .REG_AW (REG_AW)
  ) u_tagpipe (
    .clk       (clk),
    .reset     (reset),
    .flush_e_i (FlushE),
    .ra1_d_i   (RA1D),
    .ra2_d_i   (RA2D),
    .wa3_d_i   (WA3D),
    .vld_e_o   (vld_e),
    .ra1_e_o   (ra1_e),
    .ra2_e_o   (ra2_e),
    .wa3_e_o   (wa3_e),
    .vld_m_o   (vld_m),
    .wa3_m_o   (wa3_m),
    .vld_w_o   (vld_w),
    .wa3_w_o   (wa3_w)
  );

  // Forwarding matches; r15 reads are served from PC+8, never forwarded.
  always_comb begin
    hit_am = vld_e & vld_m & (ra1_e == wa3_m) & RegWriteM & (ra1_e != PC_ADDR);
    hit_aw = vld_e & vld_w & (ra1_e == wa3_w) & RegWriteW & (ra1_e != PC_ADDR);
    hit_bm = vld_e & vld_m & (ra2_e == wa3_m) & RegWriteM & (ra2_e != PC_ADDR);
    hit_bw = vld_e & vld_w & (ra2_e == wa3_w) & RegWriteW & (ra2_e != PC_ADDR);
    ForwardAE = fwd_pick(hit_am, hit_aw);
    ForwardBE = fwd_pick(hit_bm, hit_bw);
  end

  // Stall/flush decisions. A load in E cannot forward in time, so the
  // dependent instruction waits in D while a bubble enters E.
  always_comb begin
    ldr_stall     = vld_e & MemtoRegE & ((RA1D == wa3_e) | (RA2D == wa3_e));
    pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
    StallF        = ldr_stall | pc_wr_pending;
    StallD        = ldr_stall;
    FlushD        = pc_wr_pending | PCSrcW | BranchTakenE;
    FlushE        = ldr_stall | BranchTakenE;
  end

  // Counter next-state.
  always_comb begin
    stall_cnt_d = ldr_stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = FlushD    ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  RA1D = '0, RA2D = '0, WA3D = '0;
  logic        RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic        MemtoRegE = 1'b0;
  logic        PCSrcD = 1'b0, PCSrcE = 1'b0, PCSrcM = 1'b0, PCSrcW = 1'b0;
  logic        BranchTakenE = 1'b0;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount, FlushCount;

  typedef struct packed {
    logic [3:0]  flags;   // {StallF, StallD, FlushD, FlushE}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   vec_no = 0;
  int   mon_no = 0;

  hazard_unit #(.REG_AW(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %0h expected %0h", mon_no, name, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("StallF",     {15'd0, StallF},    {15'd0, mon_e.flags[3]});
      chk("StallD",     {15'd0, StallD},    {15'd0, mon_e.flags[2]});
      chk("FlushD",     {15'd0, FlushD},    {15'd0, mon_e.flags[1]});
      chk("FlushE",     {15'd0, FlushE},    {15'd0, mon_e.flags[0]});
      chk("ForwardAE",  {14'd0, ForwardAE}, {14'd0, mon_e.fa});
      chk("ForwardBE",  {14'd0, ForwardBE}, {14'd0, mon_e.fb});
      chk("StallCount", StallCount,         mon_e.sc);
      chk("FlushCount", FlushCount,         mon_e.fc);
      mon_no++;
    end
  end

  task automatic push_exp(input logic [3:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.flags = fl;
    e.fa    = fa;
    e.fb    = fb;
    e.sc    = sc;
    e.fc    = fc;
    exp_q.push_back(e);
    vec_no++;
  endtask

  // One cycle: rw = {E,M,W}, pc = {D,E,M,W}, fl = {StallF,StallD,FlushD,FlushE}.
  task automatic cyc(input logic rst, input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic [3:0] wa3, input logic [2:0] rw, input logic m2r,
                     input logic [3:0] pc, input logic bt, input logic [3:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [15:0] sc, input logic [15:0] fc);
    @(posedge clk);
    #1;
    reset        = rst;
    RA1D         = ra1;
    RA2D         = ra2;
    WA3D         = wa3;
    {RegWriteE, RegWriteM, RegWriteW}  = rw;
    MemtoRegE    = m2r;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW}   = pc;
    BranchTakenE = bt;
    push_exp(fl, fa, fb, sc, fc);
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    // Back-to-back ALU dependency: ADD r1 ; SUB r1
    cyc(1, 2, 3, 1,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 1, 4, 5,   3'b100, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 0, 0, 0,   3'b110, 0, 4'b0000, 0, 4'b0000, 2'd2, 2'd0, 0, 0);
    // Dependency two apart: X writes r7, unrelated U, Y reads r7
    cyc(1, 8, 9, 7,   3'b011, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 10, 11, 12, 3'b101, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 7, 13, 14, 3'b110, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 0, 0, 0,   3'b111, 0, 4'b0000, 0, 4'b0000, 2'd1, 2'd0, 0, 0);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    // M and W both write r1: M wins
    cyc(1, 0, 0, 1,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 0, 0, 1,   3'b100, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 1, 1, 2,   3'b110, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 0, 0, 0,   3'b011, 0, 4'b0000, 0, 4'b0000, 2'd2, 2'd2, 0, 0);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    // Load-use: LDR r2 ; ADD reads r2 as RA2
    cyc(1, 3, 0, 2,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 4, 2, 5,   3'b100, 1, 4'b0000, 0, 4'b1101, 2'd0, 2'd0, 0, 0);
    cyc(1, 4, 2, 5,   3'b010, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 0);
    cyc(1, 0, 0, 0,   3'b101, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd1, 1, 0);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 0);
    // Taken branch, no pending PC write
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 1, 4'b0011, 2'd0, 2'd0, 1, 0);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 1);
    // MOV pc travelling D -> W
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b1000, 0, 4'b1010, 2'd0, 2'd0, 1, 1);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0100, 0, 4'b1010, 2'd0, 2'd0, 1, 2);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0010, 0, 4'b1010, 2'd0, 2'd0, 1, 3);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0001, 0, 4'b0010, 2'd0, 2'd0, 1, 4);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 5);
    // r15 never forwarded even when M writes r15
    cyc(1, 0, 0, 15,  3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 5);
    cyc(1, 15, 15, 3, 3'b100, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 5);
    cyc(1, 0, 0, 0,   3'b010, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 5);
    // Load-use coinciding with a taken branch
    cyc(1, 0, 0, 9,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 1, 5);
    cyc(1, 9, 1, 4,   3'b000, 1, 4'b0000, 1, 4'b1111, 2'd0, 2'd0, 1, 5);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 2, 6);
    // Reset asserted in the middle of a load-use stall
    cyc(1, 0, 0, 6,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 2, 6);
    cyc(1, 6, 0, 7,   3'b000, 1, 4'b0000, 0, 4'b1101, 2'd0, 2'd0, 2, 6);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp(4'b0000, 2'd0, 2'd0, 0, 0);
    // Release with the load still flagged: E is empty, so no stall
    cyc(1, 6, 0, 7,   3'b000, 1, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);
    cyc(1, 0, 0, 0,   3'b000, 0, 4'b0000, 0, 4'b0000, 2'd0, 2'd0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
